// File: rtl/instr_issuer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_issuer_pkg
//  Description : Shared types and constants for the instruction issuer:
//                FSM state encoding, instruction width, default sizing.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_issuer_pkg;

    localparam int c_instr_w         = 16;
    localparam int c_default_depth   = 8;
    localparam int c_default_timeout = 4;

    typedef logic [2:0] state_t;

    localparam state_t c_st_idle      = 3'd0;
    localparam state_t c_st_load      = 3'd1;
    localparam state_t c_st_start     = 3'd2;
    localparam state_t c_st_wait_busy = 3'd3;
    localparam state_t c_st_wait_done = 3'd4;

endpackage
`default_nettype wire

// File: rtl/issue_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : issue_fifo
//  Description : Circular instruction buffer with sticky overflow flag.
//                Ports: i_push/i_data enqueue, i_pop dequeues the head,
//                o_head shows the head (zero when empty), o_count/o_full/
//                o_empty report occupancy, o_overflow is sticky until
//                i_clr_overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module issue_fifo
    import instr_issuer_pkg::*;
#(
    parameter int DEPTH = c_default_depth
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [c_instr_w-1:0]       i_data,
    input  logic                       i_pop,
    input  logic                       i_clr_overflow,
    output logic [c_instr_w-1:0]       o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_overflow
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [c_instr_w-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_overflow;

    logic w_full;
    logic w_empty;
    logic w_pop_ok;
    logic w_push_ok;

    assign w_full    = (r_count == c_cnt_w'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop_ok  = i_pop && !w_empty;
    // A pop in the same cycle frees a slot, so a write while full is legal.
    assign w_push_ok = i_push && (!w_full || w_pop_ok);

    // When full and popping, wr_ptr equals rd_ptr: the new word overwrites
    // the head that is leaving on this same edge.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - 1'b1;
            end
            if (i_clr_overflow) begin
                r_overflow <= 1'b0;
            end
            if (i_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_head     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/instr_issuer.sv
`default_nettype none
// ============================================================================
//  Module      : instr_issuer
//  Description : Host-side sequencer for the CPU instruction-load handshake.
//                Buffers host instructions and, on go, issues each one:
//                cpu_load, then cpu_s, then waits for cpu_w to fall and rise,
//                capturing {N,V,Z} and popping the buffer.
//                Host side : wr_en/wr_data, go, full, count, busy, done,
//                            overflow, timeout_err, status.
//                CPU side  : cpu_in, cpu_load, cpu_s, cpu_w, cpu_N/V/Z.
//                reset is asynchronous, active low.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_issuer
    import instr_issuer_pkg::*;
#(
    parameter int DEPTH   = c_default_depth,
    parameter int TIMEOUT = c_default_timeout
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [15:0]            wr_data,
    input  logic                   go,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic                   timeout_err,
    output logic [2:0]             status,
    output logic [15:0]            cpu_in,
    output logic                   cpu_load,
    output logic                   cpu_s,
    input  logic                   cpu_w,
    input  logic                   cpu_N,
    input  logic                   cpu_V,
    input  logic                   cpu_Z
);

    localparam int c_cnt_w  = $clog2(DEPTH) + 1;
    localparam int c_tcnt_w = $clog2(TIMEOUT + 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_tcnt_w-1:0] r_tcnt;
    logic [c_tcnt_w-1:0] w_tcnt_inc;
    logic [2:0]          r_status;
    logic                r_done;
    logic                r_timeout_err;

    logic                w_pop;
    logic                w_clr_err;
    logic                w_done_set;
    logic                w_timeout_set;
    logic                w_empty;
    logic [c_cnt_w-1:0]  w_count;

    issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk            (clk),
        .rst_n          (reset),
        .i_push         (wr_en),
        .i_data         (wr_data),
        .i_pop          (w_pop),
        .i_clr_overflow (w_clr_err),
        .o_head         (cpu_in),
        .o_count        (w_count),
        .o_full         (full),
        .o_empty        (w_empty),
        .o_overflow     (overflow)
    );

    assign w_tcnt_inc = r_tcnt + 1'b1;

    always_comb begin
        w_state_nxt   = r_state;
        w_pop         = 1'b0;
        w_clr_err     = 1'b0;
        w_done_set    = 1'b0;
        w_timeout_set = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (go && !w_empty && cpu_w) begin
                    w_state_nxt = c_st_load;
                    w_clr_err   = 1'b1;
                end
            end
            c_st_load: begin
                w_state_nxt = c_st_start;
            end
            c_st_start: begin
                w_state_nxt = c_st_wait_busy;
            end
            c_st_wait_busy: begin
                if (!cpu_w) begin
                    w_state_nxt = c_st_wait_done;
                end else if (w_tcnt_inc == c_tcnt_w'(TIMEOUT)) begin
                    // Instruction stays queued so the host can retry it.
                    w_timeout_set = 1'b1;
                    w_state_nxt   = c_st_idle;
                end
            end
            c_st_wait_done: begin
                if (cpu_w) begin
                    w_pop = 1'b1;
                    // Last entry leaving with no write landing beside it.
                    // DEPTH >= 2 means a write at count 1 is always accepted.
                    if ((w_count == c_cnt_w'(1)) && !wr_en) begin
                        w_done_set  = 1'b1;
                        w_state_nxt = c_st_idle;
                    end else begin
                        w_state_nxt = c_st_load;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= c_st_idle;
            r_tcnt        <= '0;
            r_status      <= 3'b000;
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_set;
            if (r_state == c_st_start) begin
                r_tcnt <= '0;
            end else if ((r_state == c_st_wait_busy) && cpu_w) begin
                r_tcnt <= w_tcnt_inc;
            end
            if (w_pop) begin
                r_status <= {cpu_N, cpu_V, cpu_Z};
            end
            if (w_clr_err) begin
                r_timeout_err <= 1'b0;
            end else if (w_timeout_set) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign count       = w_count;
    assign busy        = (r_state != c_st_idle);
    assign done        = r_done;
    assign timeout_err = r_timeout_err;
    assign status      = r_status;
    assign cpu_load    = (r_state == c_st_load);
    assign cpu_s       = (r_state == c_st_start);

endmodule
`default_nettype wire

// File: tb/tb_instr_issuer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_issuer
//  Description : Self-checking bench for instr_issuer with a behavioural CPU
//                and an in-order scoreboard of issued instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_issuer;

    logic        clk     = 1'b0;
    logic        reset   = 1'b0;
    logic        wr_en   = 1'b0;
    logic [15:0] wr_data = 16'h0000;
    logic        go      = 1'b0;
    logic        cpu_w   = 1'b1;
    logic        cpu_N   = 1'b0;
    logic        cpu_V   = 1'b0;
    logic        cpu_Z   = 1'b0;

    logic        full;
    logic [3:0]  count;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        timeout_err;
    logic [2:0]  status;
    logic [15:0] cpu_in;
    logic        cpu_load;
    logic        cpu_s;

    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    int          load_cnt = 0;
    int          done_cnt = 0;
    int          load_cyc[$];
    logic [15:0] sb_q[$];
    logic        cpu_stuck = 1'b0;
    logic [15:0] model_ir  = 16'h0000;
    int          d0;
    int          l0;

    instr_issuer #(
        .DEPTH   (8),
        .TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .go          (go),
        .full        (full),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .timeout_err (timeout_err),
        .status      (status),
        .cpu_in      (cpu_in),
        .cpu_load    (cpu_load),
        .cpu_s       (cpu_s),
        .cpu_w       (cpu_w),
        .cpu_N       (cpu_N),
        .cpu_V       (cpu_V),
        .cpu_Z       (cpu_Z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flags the CPU model reports for an instruction.
    function automatic logic [2:0] flags_of(input logic [15:0] ir);
        return ir[2:0] ^ 3'b100;
    endfunction

    // CPU model: w falls one cycle after cpu_s, rises three cycles later.
    always @(negedge clk) begin
        if (cpu_load) model_ir = cpu_in;
        if (cpu_s && !cpu_stuck) begin
            @(negedge clk);
            cpu_w = 1'b0;
            repeat (3) @(negedge clk);
            {cpu_N, cpu_V, cpu_Z} = flags_of(model_ir);
            cpu_w = 1'b1;
        end
    end

    // Monitor: in-order scoreboard of issued instructions.
    always @(negedge clk) begin
        cyc++;
        if (cpu_load && cpu_s) chk("load_s_exclusive", 32'(cpu_load & cpu_s), 32'd0);
        if (cpu_load) begin
            load_cnt++;
            load_cyc.push_back(cyc);
            if (sb_q.size() == 0) chk("sb_has_entry", 32'(sb_q.size()), 32'd1);
            else chk("cpu_in_order", 32'(cpu_in), 32'(sb_q.pop_front()));
        end
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [15:0] d, input bit accepted);
        wr_en   = 1'b1;
        wr_data = d;
        if (accepted) sb_q.push_back(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string tag);
        int n = 0;
        while (done !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_w(input logic lvl, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (cpu_w !== lvl && n < 20);
        chk(tag, 32'(cpu_w), 32'(lvl));
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", 32'({full, done, overflow, timeout_err, status, cpu_load, cpu_s}), 32'd0);
        chk("rst_cpu_in", 32'(cpu_in), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Single instruction
        write(16'hD105, 1'b1);
        chk("t1_count_after_wr", 32'(count), 32'd1);
        chk("t1_head", 32'(cpu_in), 32'hD105);
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("t1_load", 32'(cpu_load), 32'd1);
        chk("t1_cpu_in", 32'(cpu_in), 32'hD105);
        chk("t1_busy", 32'(busy), 32'd1);
        tick();
        chk("t1_start", 32'(cpu_s), 32'd1);
        chk("t1_load_low", 32'(cpu_load), 32'd0);
        wait_done(20, "t1_done");
        chk("t1_status", 32'(status), 32'b001);
        chk("t1_count", 32'(count), 32'd0);
        tick();
        chk("t1_done_one_cycle", 32'(done), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);

        // Back-to-back
        d0 = done_cnt;
        load_cyc.delete();
        write(16'h1111, 1'b1);
        write(16'h2222, 1'b1);
        write(16'h3333, 1'b1);
        go = 1'b1;
        tick();
        go = 1'b0;
        wait_done(60, "t2_done");
        tick();
        chk("t2_loads", 32'(load_cyc.size()), 32'd3);
        chk("t2_gap1", 32'(load_cyc[1] - load_cyc[0]), 32'd6);
        chk("t2_gap2", 32'(load_cyc[2] - load_cyc[1]), 32'd6);
        chk("t2_single_done", 32'(done_cnt - d0), 32'd1);
        chk("t2_status", 32'(status), 32'(flags_of(16'h3333)));

        // Full and wrap
        for (int i = 0; i < 8; i++) write(16'h8000 + 16'(i), 1'b1);
        write(16'hDEAD, 1'b0);
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_count8", 32'(count), 32'd8);
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("t3_ovf_cleared", 32'(overflow), 32'd0);
        wait_w(1'b0, "t3_wfall");
        wait_w(1'b1, "t3_wrise");
        wr_en   = 1'b1;
        wr_data = 16'hEEEE;
        sb_q.push_back(16'hEEEE);
        tick();
        wr_en = 1'b0;
        chk("t3_count_hold", 32'(count), 32'd8);
        chk("t3_full_hold", 32'(full), 32'd1);
        wait_done(200, "t3_done");
        tick();
        chk("t3_sb_drained", 32'(sb_q.size()), 32'd0);
        chk("t3_count0", 32'(count), 32'd0);
        chk("t3_status", 32'(status), 32'(flags_of(16'hEEEE)));

        // Timeout
        cpu_stuck = 1'b1;
        d0 = done_cnt;
        write(16'hABCD, 1'b1);
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat (5) tick();
        chk("t4_no_err_yet", 32'(timeout_err), 32'd0);
        chk("t4_busy_wb", 32'(busy), 32'd1);
        tick();
        chk("t4_timeout", 32'(timeout_err), 32'd1);
        chk("t4_idle", 32'(busy), 32'd0);
        chk("t4_count_kept", 32'(count), 32'd1);
        tick();
        chk("t4_no_done", 32'(done_cnt - d0), 32'd0);
        cpu_stuck = 1'b0;
        sb_q.push_back(16'hABCD);
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("t4_err_cleared", 32'(timeout_err), 32'd0);
        wait_done(30, "t4_retry_done");
        chk("t4_status", 32'(status), 32'(flags_of(16'hABCD)));

        // Reset mid-run
        write(16'h5A5A, 1'b1);
        go = 1'b1;
        tick();
        go = 1'b0;
        wait_w(1'b0, "t5_wfall");
        tick();
        chk("t5_in_wait_done", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_status", 32'(status), 32'd0);
        chk("t5_load_s", 32'({cpu_load, cpu_s}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) tick();
        chk("t5_stays_idle", 32'(busy), 32'd0);

        // Ignored go
        d0 = done_cnt;
        l0 = load_cnt;
        go = 1'b1;
        repeat (3) tick();
        go = 1'b0;
        chk("t6_empty_idle", 32'(busy), 32'd0);
        chk("t6_empty_noload", 32'(load_cnt - l0), 32'd0);
        chk("t6_empty_nodone", 32'(done_cnt - d0), 32'd0);
        write(16'h7777, 1'b1);
        cpu_w = 1'b0;
        go    = 1'b1;
        repeat (3) tick();
        chk("t6_wlow_idle", 32'(busy), 32'd0);
        chk("t6_wlow_noload", 32'(load_cnt - l0), 32'd0);
        cpu_w = 1'b1;
        tick();
        go = 1'b0;
        chk("t6_go_load", 32'(cpu_load), 32'd1);
        wait_done(30, "t6_done");
        chk("t6_status", 32'(status), 32'(flags_of(16'h7777)));
        tick();
        chk("t6_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
